// File: rtl/icap_pkg.sv
// rtl/icap_pkg.sv - ICAP command words, FSM state encoding and warm-boot word list
package icap_pkg;

  localparam logic [31:0] DUMMY     = 32'hFFFF_FFFF;
  localparam logic [31:0] SYNC      = 32'hAA99_5566;
  localparam logic [31:0] NOOP      = 32'h2000_0000;
  localparam logic [31:0] WR_WBSTAR = 32'h3002_0001;
  localparam logic [31:0] WR_CMD    = 32'h3000_8001;
  localparam logic [31:0] CMD_IPROG = 32'h0000_000F;

  localparam int BASE_WORDS = 7;
  // Wide enough for BASE_WORDS plus the largest NOOP tail (8), including the final increment.
  localparam int WORD_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } icap_state_t;

  function automatic logic [31:0] seq_word(input logic [WORD_CNT_W-1:0] idx,
                                           input logic [31:0] addr);
    case (idx)
      4'd0:    seq_word = DUMMY;
      4'd1:    seq_word = SYNC;
      4'd2:    seq_word = NOOP;
      4'd3:    seq_word = WR_WBSTAR;
      4'd4:    seq_word = addr;
      4'd5:    seq_word = WR_CMD;
      4'd6:    seq_word = CMD_IPROG;
      default: seq_word = NOOP;
    endcase
  endfunction

endpackage

// File: rtl/icap_word_serializer.sv
// rtl/icap_word_serializer.sv - picks one ICAP-width beat of a word, MS slice first, optional per-byte bit reversal
module icap_word_serializer
  import icap_pkg::*;
#(
  parameter int ICAP_WIDTH = 32,
  parameter bit BIT_SWAP   = 1'b1
) (
  input  logic [31:0] word,
  input  logic [1:0]  beat,
  output logic [31:0] data
);

  localparam int K = 32 / ICAP_WIDTH;
  localparam logic [31:0] MASK = (ICAP_WIDTH == 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << ICAP_WIDTH) - 32'd1);

  logic [31:0] slice;

  always_comb begin
    slice = '0;
    for (int b = 0; b < K; b++) begin
      if (beat == 2'(b)) slice = (word >> (ICAP_WIDTH * (K - 1 - b))) & MASK;
    end
  end

  // Unused upper bytes are zero, so reversing all four bytes leaves them zero.
  always_comb begin
    data = slice;
    if (BIT_SWAP) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 8; j++) data[8*k+j] = slice[8*k+7-j];
      end
    end
  end

endmodule

// File: rtl/icape2_model.sv
// rtl/icape2_model.sv - behavioural stand-in for the ICAPE2 configuration port primitive
module ICAPE2 #(
  parameter logic [31:0] DEVICE_ID  = 32'h0362_D093,
  parameter string       ICAP_WIDTH = "X32"
) (
  input  logic        CLK,
  input  logic        CSIB,
  input  logic        RDWRB,
  input  logic [31:0] I,
  output logic [31:0] O
);

  localparam logic [31:0] O_MASK = (ICAP_WIDTH == "X8")  ? 32'h0000_00FF :
                                   (ICAP_WIDTH == "X16") ? 32'h0000_FFFF : 32'hFFFF_FFFF;

  logic [31:0] last_word;

  always_ff @(posedge CLK) begin
    if (!CSIB && !RDWRB) last_word <= I;
    O <= (RDWRB ? DEVICE_ID : last_word) & O_MASK;
  end

endmodule

// File: rtl/icap_multiboot_ctrl.sv
// rtl/icap_multiboot_ctrl.sv - issues the WBSTAR + IPROG warm-boot sequence through ICAPE2
module icap_multiboot_ctrl
  import icap_pkg::*;
#(
  parameter int          ICAP_WIDTH   = 32,
  parameter logic [31:0] DEFAULT_ADDR = 32'h0007_D000,
  parameter int          NOOP_TAIL    = 1,
  parameter bit          BIT_SWAP     = 1'b1,
  parameter logic [31:0] DEVICE_ID    = 32'h0362_D093
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] boot_addr,
  input  logic        use_default,
  output logic        busy,
  output logic        done,
  output logic        start_ignored,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i
);

  localparam int K      = 32 / ICAP_WIDTH;
  localparam int NWORDS = BASE_WORDS + NOOP_TAIL;
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(NWORDS - 1);
  localparam logic [1:0]            LAST_BEAT = 2'(K - 1);

  icap_state_t            state, state_nxt;
  logic [WORD_CNT_W-1:0]  word_cnt;
  logic [1:0]             beat_cnt;
  logic [31:0]            addr_q;
  logic [31:0]            ser_data;
  logic                   last_beat;

  assign last_beat = (beat_cnt == LAST_BEAT) && (word_cnt == LAST_WORD);

  icap_word_serializer #(
    .ICAP_WIDTH (ICAP_WIDTH),
    .BIT_SWAP   (BIT_SWAP)
  ) u_ser (
    .word (seq_word(word_cnt, addr_q)),
    .beat (beat_cnt),
    .data (ser_data)
  );

  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      beat_cnt <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) addr_q <= use_default ? DEFAULT_ADDR : boot_addr;
      if (state == ST_SEND) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
          word_cnt <= word_cnt + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else begin
        beat_cnt <= '0;
        word_cnt <= '0;
      end
    end
  end

  // rdwrb only moves in cycles where csib is high (SETUP, HOLD, DONE, IDLE).
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    icap_csib  = 1'b1;
    icap_rdwrb = 1'b0;
    icap_i     = '0;
    case (state)
      ST_IDLE: begin
        busy       = 1'b0;
        icap_rdwrb = 1'b1;
        if (start) state_nxt = ST_SETUP;
      end
      ST_SETUP: state_nxt = ST_SEND;
      ST_SEND: begin
        icap_csib = 1'b0;
        icap_i    = ser_data;
        if (last_beat) state_nxt = ST_HOLD;
      end
      ST_HOLD: state_nxt = ST_DONE;
      ST_DONE: begin
        icap_rdwrb = 1'b1;
        done       = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        icap_rdwrb = 1'b1;
        state_nxt  = ST_IDLE;
      end
    endcase
    start_ignored = start & busy & ~rst;
  end

  logic [31:0] icap_o;
  logic        unused_icap_o;
  assign unused_icap_o = ^icap_o;

  if (ICAP_WIDTH == 8) begin : g_icap_x8
    ICAPE2 #(.DEVICE_ID(DEVICE_ID), .ICAP_WIDTH("X8")) u_icap (
      .CLK(sclk), .CSIB(icap_csib), .RDWRB(icap_rdwrb), .I(icap_i), .O(icap_o));
  end else if (ICAP_WIDTH == 16) begin : g_icap_x16
    ICAPE2 #(.DEVICE_ID(DEVICE_ID), .ICAP_WIDTH("X16")) u_icap (
      .CLK(sclk), .CSIB(icap_csib), .RDWRB(icap_rdwrb), .I(icap_i), .O(icap_o));
  end else begin : g_icap_x32
    ICAPE2 #(.DEVICE_ID(DEVICE_ID), .ICAP_WIDTH("X32")) u_icap (
      .CLK(sclk), .CSIB(icap_csib), .RDWRB(icap_rdwrb), .I(icap_i), .O(icap_o));
  end

endmodule

// File: tb/tb_icap_multiboot_ctrl.sv
// tb/tb_icap_multiboot_ctrl.sv - directed bench for icap_multiboot_ctrl at X32, X16 and X8 widths
module tb_icap_multiboot_ctrl;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  always #5 sclk = ~sclk;

  logic        start[3];
  logic [31:0] boot_addr[3];
  logic        use_def[3];
  logic        busy[3], done[3], ign[3], csib[3], rdwrb[3];
  logic [31:0] icap_i[3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          beat_n[3];
  int          done_n[3];
  int          done_cyc[3];
  int          viol[3];
  logic [31:0] beat_buf[3][128];
  logic        prev_csib[3], prev_rdwrb[3];

  // d0: X32 no swap, d1: X16 no swap, d2: X8 swapped with a 3-word NOOP tail
  icap_multiboot_ctrl #(.ICAP_WIDTH(32), .BIT_SWAP(1'b0), .NOOP_TAIL(1)) dut32 (
    .sclk(sclk), .rst(rst), .start(start[0]), .boot_addr(boot_addr[0]), .use_default(use_def[0]),
    .busy(busy[0]), .done(done[0]), .start_ignored(ign[0]),
    .icap_csib(csib[0]), .icap_rdwrb(rdwrb[0]), .icap_i(icap_i[0]));

  icap_multiboot_ctrl #(.ICAP_WIDTH(16), .BIT_SWAP(1'b0), .NOOP_TAIL(1)) dut16 (
    .sclk(sclk), .rst(rst), .start(start[1]), .boot_addr(boot_addr[1]), .use_default(use_def[1]),
    .busy(busy[1]), .done(done[1]), .start_ignored(ign[1]),
    .icap_csib(csib[1]), .icap_rdwrb(rdwrb[1]), .icap_i(icap_i[1]));

  icap_multiboot_ctrl #(.ICAP_WIDTH(8), .BIT_SWAP(1'b1), .NOOP_TAIL(3)) dut8 (
    .sclk(sclk), .rst(rst), .start(start[2]), .boot_addr(boot_addr[2]), .use_default(use_def[2]),
    .busy(busy[2]), .done(done[2]), .start_ignored(ign[2]),
    .icap_csib(csib[2]), .icap_rdwrb(rdwrb[2]), .icap_i(icap_i[2]));

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    for (int d = 0; d < 3; d++) begin
      if (csib[d] === 1'b0 && beat_n[d] < 128) begin
        beat_buf[d][beat_n[d]] <= icap_i[d];
        beat_n[d] <= beat_n[d] + 1;
      end
      if (done[d] === 1'b1) begin
        done_n[d]   <= done_n[d] + 1;
        done_cyc[d] <= cyc;
      end
      if (prev_csib[d] === 1'b0 && csib[d] === 1'b0 && rdwrb[d] !== prev_rdwrb[d])
        viol[d] <= viol[d] + 1;
      prev_csib[d]  <= csib[d];
      prev_rdwrb[d] <= rdwrb[d];
    end
  end

  function automatic logic [31:0] exp_beat(input int d, input int n, input logic [31:0] addr);
    int w;
    int k;
    int b;
    logic [31:0] word, sl, r;
    w = (d == 0) ? 32 : (d == 1) ? 16 : 8;
    k = 32 / w;
    b = n % k;
    case (n / k)
      0:       word = 32'hFFFF_FFFF;
      1:       word = 32'hAA99_5566;
      2:       word = 32'h2000_0000;
      3:       word = 32'h3002_0001;
      4:       word = addr;
      5:       word = 32'h3000_8001;
      6:       word = 32'h0000_000F;
      default: word = 32'h2000_0000;
    endcase
    sl = '0;
    for (int i = 0; i < w; i++) sl[i] = word[32 - (b + 1) * w + i];
    r = sl;
    if (d == 2) begin
      r = '0;
      for (int i = 0; i < w; i++) r[i] = sl[(i / 8) * 8 + 7 - (i % 8)];
    end
    return r;
  endfunction

  task automatic pulse_start(input int d, input logic [31:0] addr, input logic ud, output int dcyc);
    @(posedge sclk); #1;
    start[d] = 1'b1; boot_addr[d] = addr; use_def[d] = ud;
    dcyc = cyc;
    @(posedge sclk); #1;
    start[d] = 1'b0; boot_addr[d] = 32'hDEAD_BEEF; use_def[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int prev, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge sclk); #1;
      if (done_n[d] > prev) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge sclk); #1;
    for (int d = 0; d < 3; d++) begin
      total += 6;
      if (csib[d] !== 1'b1)   begin bad++; $display("FAIL reset_csib[%0d]: got %b want 1", d, csib[d]); end
      if (rdwrb[d] !== 1'b1)  begin bad++; $display("FAIL reset_rdwrb[%0d]: got %b want 1", d, rdwrb[d]); end
      if (icap_i[d] !== 32'h0) begin bad++; $display("FAIL reset_icap_i[%0d]: got %h want 0", d, icap_i[d]); end
      if (busy[d] !== 1'b0)   begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
      if (done[d] !== 1'b0)   begin bad++; $display("FAIL reset_done[%0d]: got %b want 0", d, done[d]); end
      if (ign[d] !== 1'b0)    begin bad++; $display("FAIL reset_ign[%0d]: got %b want 0", d, ign[d]); end
    end
  endtask

  task automatic test_w32;
    int base, prev, dc;
    bit ok;
    base = beat_n[0]; prev = done_n[0];
    pulse_start(0, 32'h0012_3400, 1'b0, dc);
    wait_done(0, prev, ok);
    total++; if (!ok) begin bad++; $display("FAIL w32_timeout: got no done want done"); end
    total += 2;
    if (done_cyc[0] - dc !== 11) begin bad++; $display("FAIL w32_done_lat: got %0d want 11", done_cyc[0] - dc); end
    if (beat_buf[0][base+4] !== 32'h0012_3400) begin bad++; $display("FAIL w32_beat5: got %h want 00123400", beat_buf[0][base+4]); end
    @(negedge sclk); #1;
    total += 3;
    if (beat_n[0] - base !== 8) begin bad++; $display("FAIL w32_beats: got %0d want 8", beat_n[0] - base); end
    if (done_n[0] - prev !== 1) begin bad++; $display("FAIL w32_done_pulses: got %0d want 1", done_n[0] - prev); end
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL w32_busy_after: got %b want 0", busy[0]); end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (beat_buf[0][base+n] !== exp_beat(0, n, 32'h0012_3400)) begin
        bad++; $display("FAIL w32_list[%0d]: got %h want %h", n, beat_buf[0][base+n], exp_beat(0, n, 32'h0012_3400));
      end
    end
  endtask

  task automatic test_w16_default;
    int base, prev, dc;
    bit ok;
    base = beat_n[1]; prev = done_n[1];
    pulse_start(1, 32'hDEAD_BEEF, 1'b1, dc);
    wait_done(1, prev, ok);
    total++; if (!ok) begin bad++; $display("FAIL w16_timeout: got no done want done"); end
    total += 4;
    if (beat_n[1] - base !== 16) begin bad++; $display("FAIL w16_beats: got %0d want 16", beat_n[1] - base); end
    if (beat_buf[1][base+8] !== 32'h0000_0007) begin bad++; $display("FAIL w16_beat9: got %h want 00000007", beat_buf[1][base+8]); end
    if (beat_buf[1][base+9] !== 32'h0000_D000) begin bad++; $display("FAIL w16_beat10: got %h want 0000d000", beat_buf[1][base+9]); end
    if (done_cyc[1] - dc !== 19) begin bad++; $display("FAIL w16_done_lat: got %0d want 19", done_cyc[1] - dc); end
    for (int n = 0; n < 16; n++) begin
      total++;
      if (beat_buf[1][base+n] !== exp_beat(1, n, 32'h0007_D000)) begin
        bad++; $display("FAIL w16_list[%0d]: got %h want %h", n, beat_buf[1][base+n], exp_beat(1, n, 32'h0007_D000));
      end
    end
  endtask

  task automatic test_w8_swap;
    int base, prev, dc;
    bit ok;
    base = beat_n[2]; prev = done_n[2];
    pulse_start(2, 32'h0102_80FF, 1'b0, dc);
    wait_done(2, prev, ok);
    total++; if (!ok) begin bad++; $display("FAIL w8_timeout: got no done want done"); end
    total += 6;
    if (beat_n[2] - base !== 40) begin bad++; $display("FAIL w8_beats: got %0d want 40", beat_n[2] - base); end
    if (beat_buf[2][base+0] !== 32'h0000_00FF) begin bad++; $display("FAIL w8_dummy: got %h want 000000ff", beat_buf[2][base]); end
    if (beat_buf[2][base+4] !== 32'h0000_0055) begin bad++; $display("FAIL w8_sync_aa: got %h want 00000055", beat_buf[2][base+4]); end
    if (beat_buf[2][base+16] !== 32'h0000_0080) begin bad++; $display("FAIL w8_addr_b0: got %h want 00000080", beat_buf[2][base+16]); end
    if (beat_buf[2][base+36] !== 32'h0000_0004) begin bad++; $display("FAIL w8_last_noop: got %h want 00000004", beat_buf[2][base+36]); end
    if (done_cyc[2] - dc !== 43) begin bad++; $display("FAIL w8_done_lat: got %0d want 43", done_cyc[2] - dc); end
    for (int n = 0; n < 40; n++) begin
      total++;
      if (beat_buf[2][base+n] !== exp_beat(2, n, 32'h0102_80FF)) begin
        bad++; $display("FAIL w8_list[%0d]: got %h want %h", n, beat_buf[2][base+n], exp_beat(2, n, 32'h0102_80FF));
      end
    end
  endtask

  task automatic test_start_ignored;
    int base, prev, dc;
    bit ok;
    base = beat_n[0]; prev = done_n[0];
    pulse_start(0, 32'hA5A5_0F0F, 1'b0, dc);
    repeat (3) @(posedge sclk);
    #1; start[0] = 1'b1; boot_addr[0] = 32'h1111_2222; use_def[0] = 1'b1;
    @(negedge sclk); #1;
    total += 2;
    if (ign[0] !== 1'b1) begin bad++; $display("FAIL ign_pulse: got %b want 1", ign[0]); end
    if (busy[0] !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", busy[0]); end
    @(posedge sclk); #1; start[0] = 1'b0; use_def[0] = 1'b0;
    @(negedge sclk); #1;
    total++; if (ign[0] !== 1'b0) begin bad++; $display("FAIL ign_clear: got %b want 0", ign[0]); end
    wait_done(0, prev, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL ign_timeout: got no done want done"); end
    if (beat_n[0] - base !== 8) begin bad++; $display("FAIL ign_beats: got %0d want 8", beat_n[0] - base); end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (beat_buf[0][base+n] !== exp_beat(0, n, 32'hA5A5_0F0F)) begin
        bad++; $display("FAIL ign_list[%0d]: got %h want %h", n, beat_buf[0][base+n], exp_beat(0, n, 32'hA5A5_0F0F));
      end
    end
  endtask

  task automatic test_reset_mid;
    int base, prev, dc;
    bit ok;
    base = beat_n[0];
    pulse_start(0, 32'h0BAD_F00D, 1'b0, dc);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge sclk); #1;
      if (beat_n[0] - base >= 3) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL rstmid_reach: got %0d beats want 3", beat_n[0] - base); end
    rst = 1'b1;
    @(negedge sclk); #1;
    total += 6;
    if (csib[0] !== 1'b1)    begin bad++; $display("FAIL rstmid_csib: got %b want 1", csib[0]); end
    if (rdwrb[0] !== 1'b1)   begin bad++; $display("FAIL rstmid_rdwrb: got %b want 1", rdwrb[0]); end
    if (busy[0] !== 1'b0)    begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy[0]); end
    if (icap_i[0] !== 32'h0) begin bad++; $display("FAIL rstmid_icap_i: got %h want 0", icap_i[0]); end
    if (done[0] !== 1'b0)    begin bad++; $display("FAIL rstmid_done: got %b want 0", done[0]); end
    if (beat_n[0] - base !== 3) begin bad++; $display("FAIL rstmid_beats: got %0d want 3", beat_n[0] - base); end
    @(posedge sclk); #1; rst = 1'b0;
    base = beat_n[0]; prev = done_n[0];
    pulse_start(0, 32'h7654_3210, 1'b0, dc);
    wait_done(0, prev, ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL rstmid_timeout: got no done want done"); end
    if (beat_n[0] - base !== 8) begin bad++; $display("FAIL rstmid_rerun_beats: got %0d want 8", beat_n[0] - base); end
    if (done_cyc[0] - dc !== 11) begin bad++; $display("FAIL rstmid_done_lat: got %0d want 11", done_cyc[0] - dc); end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (beat_buf[0][base+n] !== exp_beat(0, n, 32'h7654_3210)) begin
        bad++; $display("FAIL rstmid_list[%0d]: got %h want %h", n, beat_buf[0][base+n], exp_beat(0, n, 32'h7654_3210));
      end
    end
  endtask

  task automatic test_back_to_back;
    int base, prev, dc;
    bit ok;
    prev = done_n[0];
    pulse_start(0, 32'h1357_9BDF, 1'b0, dc);
    wait_done(0, prev, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout: got no done want done"); end
    base = beat_n[0]; prev = done_n[0];
    start[0] = 1'b1; boot_addr[0] = 32'h2468_ACE0;
    #1;
    total++; if (ign[0] !== 1'b1) begin bad++; $display("FAIL b2b_done_ign: got %b want 1", ign[0]); end
    @(negedge sclk); #1;
    total += 2;
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy: got %b want 0", busy[0]); end
    if (ign[0] !== 1'b0)  begin bad++; $display("FAIL b2b_idle_ign: got %b want 0", ign[0]); end
    @(posedge sclk); #1; start[0] = 1'b0; boot_addr[0] = 32'hDEAD_BEEF;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy[0]); end
    wait_done(0, prev, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL b2b_second_timeout: got no done want done"); end
    if (beat_n[0] - base !== 8) begin bad++; $display("FAIL b2b_beats: got %0d want 8", beat_n[0] - base); end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (beat_buf[0][base+n] !== exp_beat(0, n, 32'h2468_ACE0)) begin
        bad++; $display("FAIL b2b_list[%0d]: got %h want %h", n, beat_buf[0][base+n], exp_beat(0, n, 32'h2468_ACE0));
      end
    end
  endtask

  task automatic test_protocol;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (viol[d] !== 0) begin bad++; $display("FAIL rdwrb_stable[%0d]: got %0d changes want 0", d, viol[d]); end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0; boot_addr[d] = 32'h0; use_def[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge sclk);
    test_reset;
    @(posedge sclk); #1; rst = 1'b0;
    test_w32;
    test_w16_default;
    test_w8_swap;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    test_protocol;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icap_multiboot_ctrl.md
ICAP_MULTIBOOT_CTRL -- requirements
Module: icap_multiboot_ctrl

Interface
REQ-001 SHALL have parameter ICAP_WIDTH, default 32: ICAP port width in bits; legal values 8, 16 and 32.
REQ-002 SHALL have parameter DEFAULT_ADDR, default 32'h0007_D000: WBSTAR value used when use_default=1.
REQ-003 SHALL have parameter NOOP_TAIL, default 1: number of trailing NOOP words after IPROG; legal range 1..8.
REQ-004 SHALL have parameter BIT_SWAP, default 1: 1 applies the ICAP per-byte bit reversal, 0 passes words straight.
REQ-005 SHALL have parameter DEVICE_ID, default 32'h0362_D093: forwarded to the ICAPE2 instance.
REQ-006 SHALL have sclk, input, 1 bit: the single clock; all logic rising-edge.
REQ-007 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have start, input, 1 bit: single-cycle request to issue a warm-boot sequence.
REQ-009 SHALL have boot_addr, input, 32 bits: WBSTAR value, sampled on an accepted start.
REQ-010 SHALL have use_default, input, 1 bit: sampled with start; 1 selects DEFAULT_ADDR.
REQ-011 SHALL have busy, output, 1 bit: sequence in progress.
REQ-012 SHALL have done, output, 1 bit: one-cycle pulse at sequence end.
REQ-013 SHALL have start_ignored, output, 1 bit: one-cycle pulse when start arrives while busy=1.
REQ-014 SHALL have icap_csib, output, 1 bit; icap_rdwrb, output, 1 bit; icap_i, output, 32 bits: mirror the ICAPE2 pins, for bench observation.

Function
REQ-015 SHALL run an FSM with states IDLE -> SETUP -> SEND -> HOLD -> DONE -> IDLE.
REQ-016 SHALL accept start only in IDLE; on acceptance it latches the address (boot_addr, or DEFAULT_ADDR if use_default=1) and enters SETUP on the next edge.
REQ-017 SHALL in SETUP drive icap_rdwrb=0 and icap_csib=1 for exactly one cycle.
REQ-018 SHALL in SEND drive icap_csib=0 and icap_rdwrb=0, presenting one beat per cycle with no gaps.
REQ-019 SHALL send this word list in order: FFFF_FFFF, AA99_5566, 2000_0000, 3002_0001, latched address, 3000_8001, 0000_000F, then NOOP_TAIL copies of 2000_0000.
REQ-020 SHALL split each word into K=32/ICAP_WIDTH beats, most-significant slice first; each beat drives icap_i[ICAP_WIDTH-1:0], with the unused upper bits 0.
REQ-021 SHALL, when BIT_SWAP=1, reverse the bit order inside every byte of each beat (bit 8k+j gets source bit 8k+7-j).
REQ-022 SHALL make SEND last exactly (7+NOOP_TAIL)*K cycles, counted by a word counter and a beat counter; the counter width is sized for the maximum count, with no wrap inside a sequence.
REQ-023 SHALL in HOLD drive icap_csib=1 and icap_rdwrb=0 for one cycle, and icap_i=0.
REQ-024 SHALL in DONE drive icap_rdwrb=1 and done=1 for one cycle, then return to IDLE.
REQ-025 SHALL hold busy=1 from SETUP through DONE inclusive, and busy=0 in IDLE.
REQ-026 SHALL drop start while busy=1, and pulse start_ignored in the same cycle that start is high; the latched address is unchanged.
REQ-027 SHALL treat a start in the DONE cycle as ignored; a start in the first IDLE cycle after DONE is accepted.
REQ-028 SHALL in IDLE drive icap_csib=1, icap_rdwrb=1 and icap_i=0.
REQ-029 SHALL never change icap_rdwrb while icap_csib=0.

Reset
REQ-030 SHALL, on rst=1 at any edge (including mid-SEND), enter IDLE, clear all counters, and set busy=0, done=0, start_ignored=0, icap_csib=1, icap_rdwrb=1, icap_i=0; the latched address is cleared to 0.
REQ-031 SHALL give rst priority over start in the same cycle.

Structure
REQ-032 SHALL place the command-word constants (DUMMY, SYNC, NOOP, WR_WBSTAR, WR_CMD, CMD_IPROG) and the FSM state encoding in the shared package icap_pkg.
REQ-033 SHALL implement the beat selection and bit-swap logic in the sub-module icap_word_serializer, which is combinational and parametrised by ICAP_WIDTH and BIT_SWAP.
REQ-034 SHALL instantiate ICAPE2 internally, with ICAP_WIDTH mapped to "X8", "X16" or "X32".

Verification
REQ-035 SHALL cover: ICAP_WIDTH=32, BIT_SWAP=0, start with boot_addr=0012_3400 -> 8 SEND beats, beat 5 = 0012_3400, done pulses 11 cycles after the start edge.
REQ-036 SHALL cover: ICAP_WIDTH=16, BIT_SWAP=0, use_default=1 -> 16 beats, beats 9 and 10 = 0007 then D000.
REQ-037 SHALL cover: ICAP_WIDTH=8, BIT_SWAP=1, NOOP_TAIL=3 -> 40 beats, first SYNC beat (AA) appears as 55.
REQ-038 SHALL cover: start pulsed 4 cycles after an accepted start -> start_ignored=1 for that cycle, and the word list is unchanged.
REQ-039 SHALL cover: rst asserted at beat 3 -> next cycle icap_csib=1, icap_rdwrb=1, busy=0; a fresh start then produces the full sequence.
REQ-040 SHALL cover: start in the DONE cycle is ignored, and a start in the following cycle is accepted.
